// File: rtl/uart_tb_tx.sv
// Bench-side UART transmitter: byte FIFO in front of an LSB-first serialiser
// with optional parity and one or two stop bits. Idle line is high.
module uart_tb_tx #(
  parameter int BAUD_DIV   = 32,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_en_i,
  input  logic [7:0]                    data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic                          word_done_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  // state  | meaning
  // IDLE   | line high, waiting for a queued byte and tx_en_i
  // START  | start bit (line low)
  // DATA   | eight data bits, LSB first
  // PARITY | optional parity bit
  // STOP   | STOP_BITS stop bits (line high)
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          full;
  logic          push;
  logic          pop;

  logic [2:0]    state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          baud_end;
  logic          stop_end;
  logic          can_start;
  logic [7:0]    head;

  assign full         = (level == LVL_FULL);
  assign ready_o      = !full;
  assign fifo_level_o = level;
  assign head         = mem[rd_ptr];

  assign baud_end  = (baud_cnt == BAUD_LAST);
  assign stop_end  = (state == STOP) && baud_end && (bit_cnt == STOP_LAST);
  assign can_start = (level != '0) && tx_en_i;
  assign push      = valid_i && !full;
  // Pop happens on the edge that enters START, from IDLE or straight out of STOP.
  assign pop       = can_start && ((state == IDLE) || stop_end);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
    end else begin
      if (state != IDLE) begin
        baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (pop) begin
            state   <= START;
            shreg   <= head;
            par_bit <= (^head) ^ (PARITY_ODD != 0);
          end
        end
        START: begin
          if (baud_end) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (baud_end) begin
            shreg <= shreg >> 1;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              state   <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (baud_end) begin
            bit_cnt <= '0;
            state   <= STOP;
          end
        end
        STOP: begin
          if (baud_end) begin
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              if (pop) begin
                state   <= START;
                shreg   <= head;
                par_bit <= (^head) ^ (PARITY_ODD != 0);
              end else begin
                state <= IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

  always_comb begin
    tx_o = 1'b1;
    case (state)
      START:   tx_o = 1'b0;
      DATA:    tx_o = shreg[0];
      PARITY:  tx_o = par_bit;
      default: tx_o = 1'b1;
    endcase
  end

  assign busy_o      = (state != IDLE);
  assign word_done_o = stop_end;

endmodule

// File: tb/tb_uart_tb_tx.sv
// Directed bench for uart_tb_tx: four instances (plain, odd parity, even
// parity, two stop bits), all at BAUD_DIV=4, checked cycle by cycle.
module tb_uart_tb_tx;

  logic       clk;
  logic       rst;
  logic       tx_en;
  logic [7:0] data;
  logic [3:0] valid_v;
  logic [3:0] ready_v;
  logic [3:0] tx_v;
  logic [3:0] busy_v;
  logic [3:0] wd_v;
  logic [3:0] lvl [4];

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tb_tx #(.BAUD_DIV(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(8)) u_base (
    .clk(clk), .rst(rst), .tx_en_i(tx_en), .data_i(data), .valid_i(valid_v[0]),
    .ready_o(ready_v[0]), .tx_o(tx_v[0]), .busy_o(busy_v[0]), .word_done_o(wd_v[0]),
    .fifo_level_o(lvl[0]));

  uart_tb_tx #(.BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1), .FIFO_DEPTH(8)) u_podd (
    .clk(clk), .rst(rst), .tx_en_i(tx_en), .data_i(data), .valid_i(valid_v[1]),
    .ready_o(ready_v[1]), .tx_o(tx_v[1]), .busy_o(busy_v[1]), .word_done_o(wd_v[1]),
    .fifo_level_o(lvl[1]));

  uart_tb_tx #(.BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(8)) u_peven (
    .clk(clk), .rst(rst), .tx_en_i(tx_en), .data_i(data), .valid_i(valid_v[2]),
    .ready_o(ready_v[2]), .tx_o(tx_v[2]), .busy_o(busy_v[2]), .word_done_o(wd_v[2]),
    .fifo_level_o(lvl[2]));

  uart_tb_tx #(.BAUD_DIV(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2), .FIFO_DEPTH(8)) u_stop2 (
    .clk(clk), .rst(rst), .tx_en_i(tx_en), .data_i(data), .valid_i(valid_v[3]),
    .ready_o(ready_v[3]), .tx_o(tx_v[3]), .busy_o(busy_v[3]), .word_done_o(wd_v[3]),
    .fifo_level_o(lvl[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at frame cycle 0 (start bit already on the line); returns one cycle past the frame.
  task automatic check_frame(input int idx, input logic [7:0] d, input int par_en,
                             input int par_odd, input int stops);
    int   len;
    int   b;
    logic e;
    len = (9 + par_en + stops) * 4;
    for (int k = 0; k < len; k++) begin
      b = k / 4;
      if (b == 0)                    e = 1'b0;
      else if (b <= 8)               e = d[b-1];
      else if (par_en != 0 && b == 9) e = (^d) ^ (par_odd != 0);
      else                           e = 1'b1;
      chk($sformatf("tx_bit[%0d] byte %0h cyc %0d", idx, d, k), 32'(tx_v[idx]), 32'(e));
      chk($sformatf("busy[%0d] cyc %0d", idx, k), 32'(busy_v[idx]), 32'd1);
      chk($sformatf("word_done[%0d] cyc %0d", idx, k), 32'(wd_v[idx]), 32'(k == len - 1));
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; tx_en = 1'b1; data = 8'h00; valid_v = 4'b0000;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      chk("reset tx", 32'(tx_v[i]), 32'd1);
      chk("reset busy", 32'(busy_v[i]), 32'd0);
      chk("reset word_done", 32'(wd_v[i]), 32'd0);
      chk("reset level", 32'(lvl[i]), 32'd0);
      chk("reset ready", 32'(ready_v[i]), 32'd1);
    end
    rst = 1'b0;
    tick();

    // single byte 0xA5
    data = 8'hA5; valid_v[0] = 1'b1;
    tick();
    chk("a5 level after push", 32'(lvl[0]), 32'd1);
    chk("a5 tx idle at accept", 32'(tx_v[0]), 32'd1);
    chk("a5 busy at accept", 32'(busy_v[0]), 32'd0);
    valid_v[0] = 1'b0;
    tick();
    chk("a5 level after pop", 32'(lvl[0]), 32'd0);
    check_frame(0, 8'hA5, 0, 0, 1);
    chk("a5 busy after frame", 32'(busy_v[0]), 32'd0);
    chk("a5 tx after frame", 32'(tx_v[0]), 32'd1);

    // back-to-back 0x00 then 0xFF
    data = 8'h00; valid_v[0] = 1'b1;
    tick();
    data = 8'hFF;
    tick();
    valid_v[0] = 1'b0;
    chk("b2b level push+pop", 32'(lvl[0]), 32'd1);
    check_frame(0, 8'h00, 0, 0, 1);
    check_frame(0, 8'hFF, 0, 0, 1);
    chk("b2b busy after", 32'(busy_v[0]), 32'd0);
    chk("b2b level after", 32'(lvl[0]), 32'd0);

    // parity: 0x07 odd -> 0, even -> 1
    data = 8'h07; valid_v[1] = 1'b1;
    tick();
    valid_v[1] = 1'b0;
    tick();
    check_frame(1, 8'h07, 1, 1, 1);
    chk("podd busy after", 32'(busy_v[1]), 32'd0);
    data = 8'h07; valid_v[2] = 1'b1;
    tick();
    valid_v[2] = 1'b0;
    tick();
    check_frame(2, 8'h07, 1, 0, 1);
    chk("peven busy after", 32'(busy_v[2]), 32'd0);

    // fill FIFO with tx disabled, then drain in order
    tx_en = 1'b0; valid_v[0] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      data = 8'h10 + 8'(i);
      tick();
      chk($sformatf("fill level %0d", i), 32'(lvl[0]), 32'((i + 1 < 8) ? i + 1 : 8));
      chk($sformatf("fill ready %0d", i), 32'(ready_v[0]), 32'(i + 1 < 8));
      chk($sformatf("fill tx idle %0d", i), 32'(tx_v[0]), 32'd1);
      chk($sformatf("fill busy %0d", i), 32'(busy_v[0]), 32'd0);
    end
    valid_v[0] = 1'b0; tx_en = 1'b1;
    tick();
    chk("drain ready after first pop", 32'(ready_v[0]), 32'd1);
    chk("drain level after first pop", 32'(lvl[0]), 32'd7);
    for (int i = 0; i < 8; i++) begin
      check_frame(0, 8'h10 + 8'(i), 0, 0, 1);
    end
    chk("drain busy after", 32'(busy_v[0]), 32'd0);
    chk("drain level after", 32'(lvl[0]), 32'd0);

    // reset during data bit 3 with a second byte queued
    data = 8'h5A; valid_v[0] = 1'b1;
    tick();
    data = 8'hC3;
    tick();
    valid_v[0] = 1'b0;
    for (int k = 0; k < 17; k++) tick();
    chk("pre-reset data bit3", 32'(tx_v[0]), 32'd1);
    chk("pre-reset level", 32'(lvl[0]), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort tx", 32'(tx_v[0]), 32'd1);
    chk("abort busy", 32'(busy_v[0]), 32'd0);
    chk("abort level", 32'(lvl[0]), 32'd0);
    chk("abort ready", 32'(ready_v[0]), 32'd1);
    chk("abort word_done", 32'(wd_v[0]), 32'd0);
    for (int k = 0; k < 50; k++) begin
      tick();
      chk($sformatf("post-abort word_done %0d", k), 32'(wd_v[0]), 32'd0);
      chk($sformatf("post-abort tx %0d", k), 32'(tx_v[0]), 32'd1);
    end

    // two stop bits, 0x3C
    data = 8'h3C; valid_v[3] = 1'b1;
    tick();
    valid_v[3] = 1'b0;
    tick();
    check_frame(3, 8'h3C, 0, 0, 2);
    chk("stop2 busy after", 32'(busy_v[3]), 32'd0);
    chk("stop2 word_done after", 32'(wd_v[3]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
